score_text_renderer: RTL and testbench

- Downstream consumer of the score/status character RAM. Converts the current VGA beam position into character-RAM reads and font-ROM lookups, then produces the text-pixel colour for a 2-row × 80-column HUD panel at the bottom of the 640×480 frame.
- Output is a 3-stage pixel pipeline. Sync and blank are delayed by the same amount, so the top-level colour mux stays aligned.

---
 rtl/score_text_renderer.sv | 153 +++++++++++++++
 tb/tb_score_text_renderer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/score_text_renderer.sv
// Bottom-of-frame 2x80 text HUD: beam position -> char RAM read -> font ROM lookup -> pixel colour.
// Three-stage pipeline advancing on pix_ce; `STATUS_BLINK_EN adds a frame counter that blinks the status field.
module score_text_renderer #(
    parameter int         PANEL_Y0 = 448,
    parameter int         COLS     = 80,
    parameter logic [3:0] FG_R     = 4'hF,
    parameter logic [3:0] FG_G     = 4'hF,
    parameter logic [3:0] FG_B     = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_ce,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        win,
    input  logic        lose,
    output logic [7:0]  read_address,
    input  logic [7:0]  ram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        text_on,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        blank_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam logic [9:0] Y_LO   = 10'(PANEL_Y0);
    localparam logic [9:0] Y_HI   = 10'(PANEL_Y0 + 32);
    localparam logic [9:0] X_HI   = 10'd640;
    localparam logic [7:0] COLS_W = 8'(COLS);

    // Stage 0 next-state
    logic       in_panel_d;
    logic [4:0] dy_d;
    logic [7:0] addr_d;

    assign in_panel_d = (DrawY >= Y_LO) && (DrawY < Y_HI) && (DrawX < X_HI);
    // Only the low 5 bits of the panel-relative row are ever needed.
    assign dy_d       = DrawY[4:0] - Y_LO[4:0];
    assign addr_d     = in_panel_d ? ({1'b0, DrawX[9:3]} + (dy_d[4] ? COLS_W : 8'd0)) : 8'd0;

    // Stage 0 registers
    logic [7:0] addr_q;
    logic [3:0] glyph_row_q;
    logic [2:0] bit_idx0_q;
    logic       in_panel_q, blank0_q, hs0_q, vs0_q;

    // Stage 1 registers
    logic [10:0] font_addr_q;
    logic        vis_q;
    logic [2:0]  bit_idx1_q;
    logic        blank1_q, hs1_q, vs1_q;

    // Stage 2 registers
    logic       text_on_q;
    logic [3:0] red_q, green_q, blue_q;
    logic       blank2_q, hs2_q, vs2_q;

    logic blink_off;

`ifdef STATUS_BLINK_EN
    logic [5:0] frame_cnt_q;
    logic       vs_prev_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_cnt_q <= 6'd0;
            vs_prev_q   <= 1'b1;
        end else if (pix_ce) begin
            vs_prev_q <= vs_in;
            if (vs_prev_q && !vs_in)
                frame_cnt_q <= frame_cnt_q + 6'd1;
        end
    end

    // addr_q is the address whose data is on ram_data during stage 1.
    assign blink_off = (win || lose) && frame_cnt_q[5] && (addr_q >= 8'd105) && (addr_q <= 8'd121);
`else
    logic unused_status;
    assign unused_status = win ^ lose;
    assign blink_off     = 1'b0;
`endif

    logic vis_d, pix_bit_d, text_on_d;
    assign vis_d     = in_panel_q && (ram_data >= 8'h20) && (ram_data <= 8'h7E) && !blink_off;
    assign pix_bit_d = font_data[3'd7 - bit_idx1_q];
    assign text_on_d = vis_q && pix_bit_d && blank1_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q      <= 8'd0;
            glyph_row_q <= 4'd0;
            bit_idx0_q  <= 3'd0;
            in_panel_q  <= 1'b0;
            blank0_q    <= 1'b0;
            hs0_q       <= 1'b1;
            vs0_q       <= 1'b1;
            font_addr_q <= 11'd0;
            vis_q       <= 1'b0;
            bit_idx1_q  <= 3'd0;
            blank1_q    <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            text_on_q   <= 1'b0;
            red_q       <= 4'd0;
            green_q     <= 4'd0;
            blue_q      <= 4'd0;
            blank2_q    <= 1'b0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
        end else if (pix_ce) begin
            addr_q      <= addr_d;
            glyph_row_q <= dy_d[3:0];
            bit_idx0_q  <= DrawX[2:0];
            in_panel_q  <= in_panel_d;
            blank0_q    <= blank_in;
            hs0_q       <= hs_in;
            vs0_q       <= vs_in;

            font_addr_q <= {ram_data[6:0], glyph_row_q};
            vis_q       <= vis_d;
            bit_idx1_q  <= bit_idx0_q;
            blank1_q    <= blank0_q;
            hs1_q       <= hs0_q;
            vs1_q       <= vs0_q;

            text_on_q   <= text_on_d;
            red_q       <= text_on_d ? FG_R : 4'd0;
            green_q     <= text_on_d ? FG_G : 4'd0;
            blue_q      <= text_on_d ? FG_B : 4'd0;
            blank2_q    <= blank1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
        end
    end

    assign read_address = addr_q;
    assign font_addr    = font_addr_q;
    assign text_on      = text_on_q;
    assign Red          = red_q;
    assign Green        = green_q;
    assign Blue         = blue_q;
    assign blank_out    = blank2_q;
    assign hs_out       = hs2_q;
    assign vs_out       = vs2_q;

endmodule

// File: tb/tb_score_text_renderer.sv
// Directed bench for score_text_renderer: steady-state vector table plus latency, stall and reset sequences.
module tb_score_text_renderer;

    logic        Clk = 1'b0;
    logic        Reset, pix_ce;
    logic [9:0]  DrawX, DrawY;
    logic        blank_in, hs_in, vs_in, win, lose;
    logic [7:0]  read_address, ram_data, font_data;
    logic [10:0] font_addr;
    logic        text_on, blank_out, hs_out, vs_out;
    logic [3:0]  Red, Green, Blue;

    score_text_renderer dut (
        .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce),
        .DrawX(DrawX), .DrawY(DrawY),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .win(win), .lose(lose),
        .read_address(read_address), .ram_data(ram_data),
        .font_addr(font_addr), .font_data(font_data),
        .text_on(text_on), .Red(Red), .Green(Green), .Blue(Blue),
        .blank_out(blank_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic [7:0]  ram;
        logic [7:0]  font;
        logic [7:0]  addr;
        logic [10:0] fa;
        logic        on;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic b,
                         input logic [7:0] rd, input logic [7:0] fd);
        DrawX = x; DrawY = y; blank_in = b; ram_data = rd; font_data = fd;
    endtask

    task automatic check_pix(input string name, input logic on);
        check({name, ".text_on"}, 32'(text_on), 32'(on));
        check({name, ".rgb"}, 32'({Red, Green, Blue}), on ? 32'h0FF0 : 32'h0);
    endtask

    task automatic apply_vec(input int i);
        drive(vecs[i].x, vecs[i].y, vecs[i].blank, vecs[i].ram, vecs[i].font);
        repeat (3) tick();
    endtask

    initial begin
        vecs[0]  = '{10'd0,   10'd448, 1'b1, 8'h53, 8'h80, 8'd0,   11'h530, 1'b1};
        vecs[1]  = '{10'd59,  10'd470, 1'b1, 8'h30, 8'h10, 8'd87,  11'h306, 1'b1};
        vecs[2]  = '{10'd59,  10'd470, 1'b1, 8'h30, 8'hEF, 8'd87,  11'h306, 1'b0};
        vecs[3]  = '{10'd8,   10'd448, 1'b1, 8'h00, 8'hFF, 8'd1,   11'h000, 1'b0};
        vecs[4]  = '{10'd0,   10'd447, 1'b1, 8'h53, 8'hFF, 8'd0,   11'h53F, 1'b0};
        vecs[5]  = '{10'd700, 10'd450, 1'b1, 8'h41, 8'hFF, 8'd0,   11'h412, 1'b0};
        vecs[6]  = '{10'd16,  10'd449, 1'b0, 8'h41, 8'hFF, 8'd2,   11'h411, 1'b0};
        vecs[7]  = '{10'd639, 10'd479, 1'b1, 8'h7E, 8'hFF, 8'd159, 11'h7EF, 1'b1};
        vecs[8]  = '{10'd0,   10'd480, 1'b1, 8'h41, 8'hFF, 8'd0,   11'h410, 1'b0};
        vecs[9]  = '{10'd0,   10'd448, 1'b1, 8'h7F, 8'hFF, 8'd0,   11'h7F0, 1'b0};
        vecs[10] = '{10'd0,   10'd448, 1'b1, 8'h20, 8'hFF, 8'd0,   11'h200, 1'b1};
        vecs[11] = '{10'd0,   10'd448, 1'b1, 8'h1F, 8'hFF, 8'd0,   11'h1F0, 1'b0};
        vecs[12] = '{10'd0,   10'd448, 1'b1, 8'hA0, 8'hFF, 8'd0,   11'h200, 1'b0};

        Reset = 1'b0; pix_ce = 1'b0; hs_in = 1'b1; vs_in = 1'b1; win = 1'b0; lose = 1'b0;
        drive(10'd0, 10'd448, 1'b1, 8'h53, 8'hFF);

        // Held in reset with pix_ce toggling
        for (int i = 0; i < 4; i++) begin
            pix_ce = ~pix_ce;
            tick();
        end
        check("rst.addr", 32'(read_address), 32'd0);
        check("rst.fa", 32'(font_addr), 32'd0);
        check_pix("rst", 1'b0);
        check("rst.blank", 32'(blank_out), 32'd0);
        check("rst.hs", 32'(hs_out), 32'd1);
        check("rst.vs", 32'(vs_out), 32'd1);
        $display("txn reset: addr=%0d text_on=%0b hs=%0b vs=%0b", read_address, text_on, hs_out, vs_out);

        Reset = 1'b1;
        pix_ce = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_vec(i);
            check($sformatf("v%0d.addr", i), 32'(read_address), 32'(vecs[i].addr));
            check($sformatf("v%0d.fa", i), 32'(font_addr), 32'(vecs[i].fa));
            check_pix($sformatf("v%0d", i), vecs[i].on);
            check($sformatf("v%0d.blank", i), 32'(blank_out), 32'(vecs[i].blank));
            $display("txn vec %0d: x=%0d y=%0d ram=%02h font=%02h -> addr=%0d fa=%03h text_on=%0b",
                     i, vecs[i].x, vecs[i].y, vecs[i].ram, vecs[i].font, read_address, font_addr, text_on);
        end

        // Exact 3-strobe latency for pixel and sync
        drive(10'd0, 10'd0, 1'b1, 8'h53, 8'h80);
        repeat (3) tick();
        drive(10'd0, 10'd448, 1'b1, 8'h53, 8'h80);
        hs_in = 1'b0;
        tick();
        check("lat1.addr", 32'(read_address), 32'd0);
        check_pix("lat1", 1'b0);
        check("lat1.hs", 32'(hs_out), 32'd1);
        tick();
        check("lat2.fa", 32'(font_addr), 32'h530);
        check_pix("lat2", 1'b0);
        check("lat2.hs", 32'(hs_out), 32'd1);
        tick();
        check_pix("lat3", 1'b1);
        check("lat3.hs", 32'(hs_out), 32'd0);
        hs_in = 1'b1;
        $display("txn latency: text_on=%0b hs_out=%0b after 3 strobes", text_on, hs_out);

        // Stall for 5 clocks, then resume
        apply_vec(1);
        pix_ce = 1'b0;
        drive(10'd0, 10'd0, 1'b1, 8'h53, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d.addr", i), 32'(read_address), 32'd87);
            check($sformatf("stall%0d.fa", i), 32'(font_addr), 32'h306);
            check_pix($sformatf("stall%0d", i), 1'b1);
        end
        pix_ce = 1'b1;
        tick();
        check("res1.addr", 32'(read_address), 32'd0);
        check_pix("res1", 1'b1);
        tick();
        check_pix("res2", 1'b1);
        tick();
        check_pix("res3", 1'b0);
        $display("txn stall: resumed, text_on=%0b addr=%0d", text_on, read_address);

        // Asynchronous reset mid-line, then release
        apply_vec(1);
        @(posedge Clk);
        #3 Reset = 1'b0;
        #1;
        check("mrst.addr", 32'(read_address), 32'd0);
        check("mrst.fa", 32'(font_addr), 32'd0);
        check_pix("mrst", 1'b0);
        check("mrst.hs", 32'(hs_out), 32'd1);
        check("mrst.vs", 32'(vs_out), 32'd1);
        tick();
        tick();
        check_pix("mrst_hold", 1'b0);
        Reset = 1'b1;
        tick();
        check("rel1.addr", 32'(read_address), 32'd87);
        check_pix("rel1", 1'b0);
        tick();
        check_pix("rel2", 1'b0);
        tick();
        check_pix("rel3", 1'b1);
        check("rel3.fa", 32'(font_addr), 32'h306);
        $display("txn reset release: text_on=%0b on strobe 3", text_on);

`ifdef STATUS_BLINK_EN
        lose = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vs_in = 1'b0; tick();
            vs_in = 1'b1; tick();
        end
        drive(10'd264, 10'd464, 1'b1, 8'h41, 8'hFF);
        repeat (3) tick();
        check("blink32.addr", 32'(read_address), 32'd113);
        check_pix("blink32.a113", 1'b0);
        drive(10'd56, 10'd448, 1'b1, 8'h41, 8'hFF);
        repeat (3) tick();
        check("blink32.a7addr", 32'(read_address), 32'd7);
        check_pix("blink32.a7", 1'b1);
        for (int i = 0; i < 32; i++) begin
            vs_in = 1'b0; tick();
            vs_in = 1'b1; tick();
        end
        drive(10'd264, 10'd464, 1'b1, 8'h41, 8'hFF);
        repeat (3) tick();
        check_pix("blink64.a113", 1'b1);
        $display("txn blink: addr 113 text_on=%0b after 64 frames", text_on);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
